// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: opcode encodings and the D-channel response entry.
package tl_pkg;

    localparam logic [2:0] TL_A_PUTFULL = 3'd0;
    localparam logic [2:0] TL_A_PUTPART = 3'd1;
    localparam logic [2:0] TL_A_GET     = 3'd4;
    localparam logic [2:0] TL_D_ACK     = 3'd0;
    localparam logic [2:0] TL_D_ACKDATA = 3'd1;

    localparam int TL_SRC_W = 4;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          size;
        logic [TL_SRC_W-1:0] source;
        logic [63:0]         data;
        logic                error;
    } tl_d_entry_t;

    // Byte lanes a request of 2**size bytes at the given word offset must cover.
    function automatic logic [7:0] tl_size_lanes(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] lanes;
        case (size)
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        return lanes << offset;
    endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Two-entry response queue; simultaneous push and pop keeps the occupancy unchanged.
module tl_resp_fifo #(
    parameter type entry_t = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  entry_t     push_data,
    input  logic       pop,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t mem [2];
    logic   rd_ptr;
    logic   wr_ptr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UL RAM responder with one-cycle latency and a 2-entry D queue.
// Define TL_RESP_ERRCHK_EN to enable range/alignment/opcode/mask error checking.
module tl_ram_responder
    import tl_pkg::*;
#(
    parameter int          DEPTH = 512,
    parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
    parameter int          SRC_W = TL_SRC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_opcode,
    input  logic [1:0]       a_size,
    input  logic [SRC_W-1:0] a_source,
    input  logic [63:0]      a_address,
    input  logic [7:0]       a_mask,
    input  logic [63:0]      a_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic [2:0]       d_opcode,
    output logic [1:0]       d_size,
    output logic [SRC_W-1:0] d_source,
    output logic [63:0]      d_data,
    output logic             d_error
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [63:0]      ram [DEPTH];
    logic [1:0]       count;
    tl_d_entry_t      head;
    tl_d_entry_t      resp;
    logic             a_fire;
    logic             d_fire;
    logic             is_get;
    logic             is_put;
    logic             err;
    logic [IDX_W-1:0] idx;

    assign a_ready = (count != 2'd2) | d_ready;
    assign d_valid = (count != 2'd0);
    assign a_fire  = a_valid & a_ready;
    assign d_fire  = d_valid & d_ready;

`ifdef TL_RESP_ERRCHK_EN
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    logic [63:0] offset;
    logic [7:0]  lanes;
    logic [2:0]  align_mask;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        offset     = a_address - BASE;
        lanes      = tl_size_lanes(a_size, a_address[2:0]);
        align_mask = 3'b000;
        case (a_size)
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            2'd3:    align_mask = 3'b111;
            default: align_mask = 3'b000;
        endcase
        is_put = (a_opcode == TL_A_PUTFULL) | (a_opcode == TL_A_PUTPART);
        is_get = (a_opcode == TL_A_GET);
        // Addresses below BASE wrap to huge offsets, so one compare covers both ends.
        err = (offset >= SPAN)
            | ((a_address[2:0] & align_mask) != 3'b000)
            | ~(is_put | is_get)
            | ((a_opcode == TL_A_PUTFULL) & ((a_mask & lanes) != lanes));
        idx = offset[3 +: IDX_W];
    end
`else
    always_comb begin
        is_put = (a_opcode == TL_A_PUTFULL) | (a_opcode == TL_A_PUTPART);
        is_get = ~is_put;
        err    = 1'b0;
        idx    = a_address[3 +: IDX_W];
    end
`endif

    always_comb begin
        resp        = '0;
        resp.opcode = is_get ? TL_D_ACKDATA : TL_D_ACK;
        resp.size   = a_size;
        resp.source = a_source;
        resp.error  = err;
        resp.data   = (is_get & ~err) ? ram[idx] : 64'd0;
    end

    // NOTE: the RAM array is deliberately not reset; only the control state is.
    always_ff @(posedge clk) begin
        if (!rst && a_fire && is_put && !err) begin
            for (int b = 0; b < 8; b++) begin
                if (a_mask[b]) begin
                    ram[idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    tl_resp_fifo #(
        .entry_t (tl_d_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (a_fire),
        .push_data (resp),
        .pop       (d_fire),
        .head      (head),
        .count     (count)
    );

    assign d_opcode = head.opcode;
    assign d_size   = head.size;
    assign d_source = head.source;
    assign d_data   = head.data;
    assign d_error  = head.error;

endmodule
